// File: rtl/key_action_gen.sv
// -----------------------------------------------------------------------------
// key_action_gen
//
// Purpose:
//   Converts the raw USB keycode into clean one-frame action pulses for the
//   sprite pick/drop (interact) and chop logic. Each press is debounced, a
//   cooldown follows every release, and chop auto-repeats while it is held.
//   Downstream logic can therefore use the pulses directly, with no private
//   debounce counter of its own.
//
// Ports:
//   frame_clk       in   1  frame clock (one rising edge per video frame)
//   Reset           in   1  asynchronous, active-high reset
//   keycode         in   8  current keycode from the USB keyboard interface
//   enable          in   1  game active; low forces IDLE and silences outputs
//   interact_pulse  out  1  one-frame pulse: interact (pick up / drop)
//   chop_pulse      out  1  one-frame pulse: chop
//   key_held        out  2  00 none, 01 interact held, 10 chop held
//   chop_count      out  8  chop pulses issued in the current hold (saturates)
//
// Parameter ranges:
//   DEBOUNCE_FRAMES 1..15, REPEAT_DELAY 1..255, REPEAT_PERIOD 1..255,
//   COOLDOWN_FRAMES 0..15. Values outside these ranges are not supported.
// -----------------------------------------------------------------------------
module key_action_gen #(
    parameter logic [7:0] INTERACT_CODE   = 8'h08,
    parameter logic [7:0] CHOP_CODE       = 8'h14,
    parameter int         DEBOUNCE_FRAMES = 3,
    parameter int         REPEAT_DELAY    = 12,
    parameter int         REPEAT_PERIOD   = 4,
    parameter int         COOLDOWN_FRAMES = 2
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       interact_pulse,
    output logic       chop_pulse,
    output logic [1:0] key_held,
    output logic [7:0] chop_count
);

    // Parameters narrowed once to the counter widths so every compare
    // below is between equally sized operands.
    localparam logic [3:0] DB_TARGET  = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0] CL_TARGET  = 4'(COOLDOWN_FRAMES);
    localparam logic [7:0] RPT_DELAY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPT_PERIOD = 8'(REPEAT_PERIOD);

    localparam logic [1:0] HELD_NONE     = 2'b00;
    localparam logic [1:0] HELD_INTERACT = 2'b01;
    localparam logic [1:0] HELD_CHOP     = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t      state_reg;
    logic [7:0]  code_reg;       // code latched when the press started
    logic [3:0]  dbcnt_reg;      // consecutive stable frames while arming
    logic [3:0]  clcnt_reg;      // frames spent in cooldown
    logic [7:0]  rptcnt_reg;     // frames since the last chop pulse
    logic        repeating_reg;  // set once the first auto-repeat has fired

    // -------------------------------------------------------------------------
    // Input decode and counter increments
    // -------------------------------------------------------------------------
    logic       key_valid;
    logic       key_is_chop;
    logic       same_code;
    logic       code_is_chop;
    logic [3:0] dbcnt_inc;
    logic [3:0] clcnt_inc;
    logic [7:0] rptcnt_inc;
    logic [7:0] rpt_target;
    logic [7:0] chop_count_inc;

    always_comb begin
        key_valid    = (keycode == INTERACT_CODE) || (keycode == CHOP_CODE);
        key_is_chop  = (keycode == CHOP_CODE);
        same_code    = (keycode == code_reg);
        code_is_chop = (code_reg == CHOP_CODE);
        dbcnt_inc    = dbcnt_reg + 4'd1;
        clcnt_inc    = clcnt_reg + 4'd1;
        rptcnt_inc   = rptcnt_reg + 8'd1;
        // The first repeat waits the longer delay; later ones use the period.
        rpt_target   = repeating_reg ? RPT_PERIOD : RPT_DELAY;
        // Saturate rather than wrap so a long hold never reads back as small.
        chop_count_inc = (chop_count == 8'hFF) ? 8'hFF : chop_count + 8'd1;
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            code_reg       <= 8'd0;
            dbcnt_reg      <= 4'd0;
            clcnt_reg      <= 4'd0;
            rptcnt_reg     <= 8'd0;
            repeating_reg  <= 1'b0;
            interact_pulse <= 1'b0;
            chop_pulse     <= 1'b0;
            key_held       <= HELD_NONE;
            chop_count     <= 8'd0;
        end else begin
            // Pulses last exactly one frame unless re-fired below.
            interact_pulse <= 1'b0;
            chop_pulse     <= 1'b0;

            if (!enable) begin
                // Game paused: drop any press in progress. A key still down
                // when enable returns must go through the full debounce.
                state_reg     <= IDLE;
                code_reg      <= 8'd0;
                dbcnt_reg     <= 4'd0;
                clcnt_reg     <= 4'd0;
                rptcnt_reg    <= 8'd0;
                repeating_reg <= 1'b0;
                key_held      <= HELD_NONE;
                chop_count    <= 8'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (key_valid) begin
                            code_reg      <= keycode;
                            dbcnt_reg     <= 4'd1;
                            rptcnt_reg    <= 8'd0;
                            repeating_reg <= 1'b0;
                            if (DB_TARGET == 4'd1) begin
                                // No debounce wanted: the first sample fires.
                                state_reg <= HOLD;
                                if (key_is_chop) begin
                                    chop_pulse <= 1'b1;
                                    key_held   <= HELD_CHOP;
                                    chop_count <= chop_count_inc;
                                end else begin
                                    interact_pulse <= 1'b1;
                                    key_held       <= HELD_INTERACT;
                                end
                            end else begin
                                state_reg <= ARM;
                            end
                        end
                    end

                    ARM: begin
                        if (same_code) begin
                            dbcnt_reg <= dbcnt_inc;
                            if (dbcnt_inc == DB_TARGET) begin
                                state_reg <= HOLD;
                                if (code_is_chop) begin
                                    chop_pulse <= 1'b1;
                                    key_held   <= HELD_CHOP;
                                    chop_count <= chop_count_inc;
                                end else begin
                                    interact_pulse <= 1'b1;
                                    key_held       <= HELD_INTERACT;
                                end
                            end
                        end else begin
                            // Bounce or a different key: abandon the press.
                            // A new valid code is picked up on the next edge.
                            state_reg <= IDLE;
                            dbcnt_reg <= 4'd0;
                        end
                    end

                    HOLD: begin
                        if (same_code) begin
                            if (code_is_chop) begin
                                if (rptcnt_inc == rpt_target) begin
                                    chop_pulse    <= 1'b1;
                                    chop_count    <= chop_count_inc;
                                    rptcnt_reg    <= 8'd0;
                                    repeating_reg <= 1'b1;
                                end else begin
                                    rptcnt_reg <= rptcnt_inc;
                                end
                            end
                        end else begin
                            // Release. The new code is deliberately not
                            // latched here; the cooldown swallows it.
                            key_held      <= HELD_NONE;
                            chop_count    <= 8'd0;
                            dbcnt_reg     <= 4'd0;
                            clcnt_reg     <= 4'd0;
                            rptcnt_reg    <= 8'd0;
                            repeating_reg <= 1'b0;
                            state_reg     <= (CL_TARGET == 4'd0) ? IDLE : COOL;
                        end
                    end

                    COOL: begin
                        // Keycode is ignored for the whole cooldown.
                        if (clcnt_inc == CL_TARGET) begin
                            state_reg <= IDLE;
                            clcnt_reg <= 4'd0;
                        end else begin
                            clcnt_reg <= clcnt_inc;
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_action_gen.sv
module tb_key_action_gen;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       enable;

    logic       ip0, cp0, ip1, cp1;
    logic [1:0] kh0, kh1;
    logic [7:0] cc0, cc1;

    always #5 frame_clk = ~frame_clk;

    // Instance 0: default parameters.
    key_action_gen dut0 (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .enable         (enable),
        .interact_pulse (ip0),
        .chop_pulse     (cp0),
        .key_held       (kh0),
        .chop_count     (cc0)
    );

    // Instance 1: no debounce, no cooldown, short repeat.
    key_action_gen #(
        .DEBOUNCE_FRAMES (1),
        .REPEAT_DELAY    (5),
        .REPEAT_PERIOD   (3),
        .COOLDOWN_FRAMES (0)
    ) dut1 (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .enable         (enable),
        .interact_pulse (ip1),
        .chop_pulse     (cp1),
        .key_held       (kh1),
        .chop_count     (cc1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;

    // Reference model. A press is described by how many consecutive frames
    // the same valid code has been seen (m_len); pulse times follow from
    // that length arithmetically.
    int         m_db   [2] = '{3, 1};
    int         m_dly  [2] = '{12, 5};
    int         m_per  [2] = '{4, 3};
    int         m_cool [2] = '{2, 0};
    int         m_len  [2];
    int         m_cleft[2];
    int         m_count[2];
    logic [7:0] m_code [2];
    logic       m_ip   [2];
    logic       m_cp   [2];
    logic [1:0] m_kh   [2];
    logic [7:0] m_cc   [2];

    function automatic bit pulse_due(input int len, input int db, input int dly,
                                     input int per, input bit is_chop);
        int f;
        if (len == db) return 1'b1;
        if (!is_chop || len < db) return 1'b0;
        f = len - db;
        if (f < dly) return 1'b0;
        return ((f - dly) % per) == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_len[i] = 0; m_cleft[i] = 0; m_count[i] = 0; m_code[i] = 8'h00;
            m_ip[i] = 1'b0; m_cp[i] = 1'b0; m_kh[i] = 2'b00; m_cc[i] = 8'h00;
        end
    endtask

    task automatic model_fire(input int i);
        if (pulse_due(m_len[i], m_db[i], m_dly[i], m_per[i], m_code[i] == 8'h14)) begin
            if (m_code[i] == 8'h08) m_ip[i] = 1'b1;
            else begin
                m_cp[i] = 1'b1;
                if (m_count[i] < 255) m_count[i]++;
            end
        end
    endtask

    task automatic model_step(input int i, input logic [7:0] k, input logic en);
        m_ip[i] = 1'b0;
        m_cp[i] = 1'b0;
        if (!en) begin
            m_len[i] = 0; m_cleft[i] = 0; m_count[i] = 0;
        end else if (m_cleft[i] > 0) begin
            m_cleft[i]--;
        end else if (m_len[i] > 0 && k == m_code[i]) begin
            m_len[i]++;
            model_fire(i);
        end else if (m_len[i] > 0) begin
            if (m_len[i] >= m_db[i]) m_cleft[i] = m_cool[i];
            m_len[i] = 0;
            m_count[i] = 0;
        end else if (k == 8'h08 || k == 8'h14) begin
            m_code[i] = k;
            m_len[i] = 1;
            model_fire(i);
        end
        if (m_len[i] > 0 && m_len[i] >= m_db[i])
            m_kh[i] = (m_code[i] == 8'h08) ? 2'b01 : 2'b10;
        else
            m_kh[i] = 2'b00;
        m_cc[i] = 8'(m_count[i]);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s frame=%0d observed=%0h expected=%0h", tag, frame_no, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("d0_interact", 8'(ip0), 8'(m_ip[0]));
        chk("d0_chop",     8'(cp0), 8'(m_cp[0]));
        chk("d0_held",     8'(kh0), 8'(m_kh[0]));
        chk("d0_count",    cc0,     m_cc[0]);
        chk("d1_interact", 8'(ip1), 8'(m_ip[1]));
        chk("d1_chop",     8'(cp1), 8'(m_cp[1]));
        chk("d1_held",     8'(kh1), 8'(m_kh[1]));
        chk("d1_count",    cc1,     m_cc[1]);
        $display("frame %0d key=%02h en=%0b | d0 ip=%0b cp=%0b kh=%0d cc=%0d | d1 ip=%0b cp=%0b kh=%0d cc=%0d",
                 frame_no, keycode, enable, ip0, cp0, kh0, cc0, ip1, cp1, kh1, cc1);
    endtask

    task automatic step(input logic [7:0] k, input logic en);
        keycode = k;
        enable  = en;
        @(posedge frame_clk);
        frame_no++;
        model_step(0, k, en);
        model_step(1, k, en);
        #1;
        check_model();
    endtask

    task automatic settle(input int n);
        for (int j = 0; j < n; j++) step(8'h00, 1'b1);
    endtask

    int         n_pulse;
    int         first_frame;
    int         start_frame;
    int         chop_frames[$];
    int         exp_frames[8] = '{3, 15, 19, 23, 27, 31, 35, 39};
    int         guard;
    logic [7:0] rk;
    logic       ren;
    int         rlen;

    initial begin
        Reset   = 1'b1;
        keycode = 8'h00;
        enable  = 1'b1;
        model_reset();
        @(posedge frame_clk);
        #1;
        check_model();
        @(negedge frame_clk);
        Reset = 1'b0;

        // Test 1: interact held 10 frames, single pulse on the 3rd frame.
        n_pulse = 0; first_frame = 0; start_frame = frame_no;
        for (int j = 0; j < 10; j++) begin
            step(8'h08, 1'b1);
            if (ip0) begin
                n_pulse++;
                if (first_frame == 0) first_frame = frame_no - start_frame;
            end
        end
        chk("t1_pulse_count", 8'(n_pulse), 8'd1);
        chk("t1_pulse_frame", 8'(first_frame), 8'd3);
        chk("t1_held", 8'(kh0), 8'd1);
        settle(4);

        // Test 2: short press aborted, then a full press.
        n_pulse = 0;
        step(8'h08, 1'b1); if (ip0) n_pulse++;
        step(8'h08, 1'b1); if (ip0) n_pulse++;
        step(8'h00, 1'b1); if (ip0) n_pulse++;
        chk("t2_no_pulse", 8'(n_pulse), 8'd0);
        for (int j = 0; j < 3; j++) begin
            step(8'h08, 1'b1);
            if (ip0) n_pulse++;
        end
        chk("t2_one_pulse", 8'(n_pulse), 8'd1);
        settle(4);

        // Test 3: chop held 40 frames, auto-repeat schedule.
        chop_frames.delete();
        start_frame = frame_no;
        for (int j = 0; j < 40; j++) begin
            step(8'h14, 1'b1);
            if (cp0) chop_frames.push_back(frame_no - start_frame);
        end
        chk("t3_pulse_total", 8'(chop_frames.size()), 8'd8);
        for (int j = 0; j < 8 && j < chop_frames.size(); j++)
            chk("t3_pulse_frame", 8'(chop_frames[j]), 8'(exp_frames[j]));
        chk("t3_chop_count", cc0, 8'd8);
        settle(4);

        // Test 4: chop then interact; release, cooldown, re-arm.
        for (int j = 0; j < 5; j++) step(8'h14, 1'b1);
        step(8'h08, 1'b1);
        chk("t4_count_cleared", cc0, 8'd0);
        chk("t4_held_cleared", 8'(kh0), 8'd0);
        for (int j = 0; j < 8; j++) step(8'h08, 1'b1);
        settle(4);

        // Test 5: asynchronous reset mid-frame during a chop hold.
        guard = 0;
        while (m_cc[0] != 8'd5 && guard < 60) begin
            step(8'h14, 1'b1);
            guard++;
        end
        chk("t5_reached_count", cc0, 8'd5);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk("t5_async_ip", 8'(ip0), 8'd0);
        chk("t5_async_cp", 8'(cp0), 8'd0);
        chk("t5_async_held", 8'(kh0), 8'd0);
        chk("t5_async_count", cc0, 8'd0);
        @(negedge frame_clk);
        Reset = 1'b0;
        step(8'h14, 1'b1);
        chk("t5_no_pulse", 8'(cp0), 8'd0);
        settle(4);

        // Test 6: enable low while chop held, then enable rises.
        for (int j = 0; j < 5; j++) step(8'h14, 1'b0);
        step(8'h14, 1'b1);
        step(8'h14, 1'b1);
        step(8'h14, 1'b1);
        chk("t6_first_chop", 8'(cp0), 8'd1);
        settle(4);

        // Instance 1: immediate re-press with no cooldown.
        step(8'h08, 1'b1);
        chk("t6_db1_first_edge", 8'(ip1), 8'd1);
        step(8'h00, 1'b1);
        step(8'h08, 1'b1);
        chk("t6_db1_repress", 8'(ip1), 8'd1);
        settle(4);

        // Randomized segments checked against the model.
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0: rk = 8'h08;
                1: rk = 8'h14;
                2: rk = 8'h00;
                default: rk = 8'(8'h20 + $urandom_range(0, 15));
            endcase
            ren  = ($urandom_range(0, 9) != 0);
            rlen = $urandom_range(1, 20);
            for (int j = 0; j < rlen; j++) step(rk, ren);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
